// File: rtl/lcd_seq_ctrl_if.sv
// Stream port of the LCD sequencer: runtime commands and pixel beats.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready; a beat moves when s_valid && s_ready.
// Signals: s_valid/s_rs/s_data driven by the source (master), s_ready by the sink (slave).
interface lcd_seq_ctrl_if #(
  parameter int DW = 16
);
  logic          s_valid;
  logic          s_rs;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (output s_valid, output s_rs, output s_data, input s_ready);
  modport slave  (input s_valid, input s_rs, input s_data, output s_ready);
endinterface

// File: rtl/lcd_seq_ctrl.sv
// 8080-style parallel LCD controller: panel reset pulse, ROM-driven init table, then a stream port.
// Latency: stream accept -> lcd_wr low 1 cycle; one beat per WR_LO_CYC+WR_HI_CYC+1 cycles.
// Backpressure: s_ready high only while idle in RUN (after init); low for the whole write.
// Ports: clk_use/reset (sync, active-high); rom_addr_o/rom_data_i to a synchronous ROM
//   ({type[1:0],payload}, data one cycle after address); lcd_* panel pins; init_done_o/init_err_o
//   status; s_if stream slave (s_valid/s_rs/s_data in, s_ready out).
module lcd_seq_ctrl #(
  parameter int DW           = 16,
  parameter int AW           = 8,
  parameter int RST_LOW_CYC  = 25000,
  parameter int RST_WAIT_CYC = 25000,
  parameter int WR_LO_CYC    = 1,
  parameter int WR_HI_CYC    = 1,
  parameter int DELAY_UNIT   = 1000
) (
  input  logic          clk_use,
  input  logic          reset,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW+1:0] rom_data_i,
  output logic [DW-1:0] lcd_data_o,
  output logic          lcd_cs_o,
  output logic          lcd_rs_o,
  output logic          lcd_wr_o,
  output logic          lcd_rst_o,
  output logic          init_done_o,
  output logic          init_err_o,
  lcd_seq_ctrl_if.slave s_if
);

  typedef enum logic [2:0] {
    ST_RST_LOW, ST_RST_WAIT, ST_FETCH, ST_DECODE, ST_WR_LO, ST_WR_HI, ST_DELAY, ST_RUN
  } state_t;

  localparam logic [1:0]  TY_CMD = 2'b00;
  localparam logic [1:0]  TY_DAT = 2'b01;
  localparam logic [1:0]  TY_DLY = 2'b10;

  localparam logic [31:0] RST_LOW_N     = 32'(RST_LOW_CYC);
  localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYC - 1);
  localparam logic [31:0] WR_LO_LAST    = 32'(WR_LO_CYC - 1);
  localparam logic [31:0] WR_HI_LAST    = 32'(WR_HI_CYC - 1);
  localparam logic [31:0] DELAY_UNIT_W  = 32'(DELAY_UNIT);

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] lcd_data_q, lcd_data_d;
  logic          lcd_cs_q, lcd_cs_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_wr_q, lcd_wr_d;
  logic          lcd_rst_q, lcd_rst_d;
  logic          init_done_q, init_done_d;
  logic          init_err_q, init_err_d;

  logic [1:0]    rom_type;
  logic [DW-1:0] rom_payload;
  logic [31:0]   dly_cycles;
  logic          accept;
  logic          advance;

  assign rom_type    = rom_data_i[DW+1:DW];
  assign rom_payload = rom_data_i[DW-1:0];
  assign dly_cycles  = 32'(rom_payload) * DELAY_UNIT_W;

  assign s_if.s_ready = (state_q == ST_RUN);
  assign accept       = s_if.s_valid && (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    lcd_data_d  = lcd_data_q;
    lcd_cs_d    = lcd_cs_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_wr_d    = lcd_wr_q;
    lcd_rst_d   = lcd_rst_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    advance     = 1'b0;

    case (state_q)
      // lcd_rst is registered: it drops one cycle after entry and rises on the
      // exit edge, so comparing against the full count gives exactly RST_LOW_CYC low cycles.
      ST_RST_LOW: begin
        if (cnt_q == RST_LOW_N) begin
          lcd_rst_d = 1'b1;
          cnt_d     = 32'd0;
          state_d   = ST_RST_WAIT;
        end else begin
          lcd_rst_d = 1'b0;
          cnt_d     = cnt_q + 32'd1;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == RST_WAIT_LAST) begin
          cnt_d   = 32'd0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      // The ROM samples rom_addr at the end of this cycle; data is seen in DECODE.
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (rom_type)
          TY_CMD, TY_DAT: begin
            lcd_rs_d   = rom_type[0];
            lcd_data_d = rom_payload;
            lcd_cs_d   = 1'b0;
            lcd_wr_d   = 1'b0;
            cnt_d      = 32'd0;
            state_d    = ST_WR_LO;
          end
          TY_DLY: begin
            if (dly_cycles == 32'd0) begin
              advance = 1'b1;
            end else begin
              lcd_cs_d = 1'b1;
              cnt_d    = dly_cycles;
              state_d  = ST_DELAY;
            end
          end
          default: begin
            init_done_d = 1'b1;
            lcd_cs_d    = 1'b1;
            state_d     = ST_RUN;
          end
        endcase
      end
      ST_WR_LO: begin
        if (cnt_q == WR_LO_LAST) begin
          lcd_wr_d = 1'b1;
          cnt_d    = 32'd0;
          state_d  = ST_WR_HI;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      // lcd_cs stays low on exit so back-to-back writes never deselect the panel.
      ST_WR_HI: begin
        if (cnt_q == WR_HI_LAST) begin
          cnt_d = 32'd0;
          if (init_done_q) begin
            state_d = ST_RUN;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DELAY: begin
        if (cnt_q == 32'd1) begin
          cnt_d   = 32'd0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          lcd_rs_d   = s_if.s_rs;
          lcd_data_d = s_if.s_data;
          lcd_cs_d   = 1'b0;
          lcd_wr_d   = 1'b0;
          cnt_d      = 32'd0;
          state_d    = ST_WR_LO;
        end else begin
          lcd_cs_d = 1'b1;
        end
      end
      default: state_d = ST_RST_LOW;
    endcase

    // Step to the next table entry; the last address has no successor, so a
    // table without END finishes with an error instead of wrapping.
    if (advance) begin
      if (rom_addr_q == '1) begin
        init_err_d  = 1'b1;
        init_done_d = 1'b1;
        state_d     = ST_RUN;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk_use) begin
    if (reset) begin
      state_q     <= ST_RST_LOW;
      cnt_q       <= 32'd0;
      rom_addr_q  <= '0;
      lcd_data_q  <= '0;
      lcd_cs_q    <= 1'b1;
      lcd_rs_q    <= 1'b1;
      lcd_wr_q    <= 1'b1;
      lcd_rst_q   <= 1'b1;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      lcd_data_q  <= lcd_data_d;
      lcd_cs_q    <= lcd_cs_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_wr_q    <= lcd_wr_d;
      lcd_rst_q   <= lcd_rst_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign lcd_data_o  = lcd_data_q;
  assign lcd_cs_o    = lcd_cs_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_wr_o    = lcd_wr_q;
  assign lcd_rst_o   = lcd_rst_q;
  assign init_done_o = init_done_q;
  assign init_err_o  = init_err_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl: reset pulse timing, init tables, delays, missing END,
// stream throughput/ordering and mid-operation reset, checked against an LCD pin model.
// Outputs are sampled on the falling edge of clk_use; inputs are driven on the falling edge.
module tb_lcd_seq_ctrl;
  localparam int DW = 16;
  localparam int AW = 2;

  localparam logic [1:0] CMD = 2'b00;
  localparam logic [1:0] DAT = 2'b01;
  localparam logic [1:0] DLY = 2'b10;
  localparam logic [1:0] ENDT = 2'b11;

  // {rom_addr, lcd_data, cs, rs, wr, rst, init_done, init_err, s_ready}
  localparam logic [24:0] EXP_RST = {2'b00, 16'h0000, 7'b1111000};

  logic          clk_use = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [DW+1:0] rom_data;
  logic [DW-1:0] lcd_data;
  logic          lcd_cs, lcd_rs, lcd_wr, lcd_rst, init_done, init_err;
  logic [DW+1:0] rom [0:3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_use = ~clk_use;

  lcd_seq_ctrl_if #(.DW(DW)) s_if ();

  lcd_seq_ctrl #(
    .DW(DW), .AW(AW), .RST_LOW_CYC(4), .RST_WAIT_CYC(4),
    .WR_LO_CYC(2), .WR_HI_CYC(1), .DELAY_UNIT(10)
  ) dut (
    .clk_use    (clk_use),
    .reset      (reset),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .lcd_data_o (lcd_data),
    .lcd_cs_o   (lcd_cs),
    .lcd_rs_o   (lcd_rs),
    .lcd_wr_o   (lcd_wr),
    .lcd_rst_o  (lcd_rst),
    .init_done_o(init_done),
    .init_err_o (init_err),
    .s_if       (s_if)
  );

  // Synchronous ROM: data one cycle after address.
  always @(posedge clk_use) rom_data <= rom[rom_addr];

  // LCD pin model: captures rs/data on each lcd_wr rising edge and records timing.
  int            cyc = 0;
  int            rst_lo_cnt, rst_rise_cyc, first_wr_lo, cs_hi_run, rdy_viol, early_rdy;
  logic          wr_prev, rst_prev;
  logic          cap_rs [$];
  logic [DW-1:0] cap_dat [$];
  int            cap_cyc [$];
  int            cap_cshi [$];

  always @(negedge clk_use) begin
    if (reset) begin
      rst_lo_cnt = 0; rst_rise_cyc = -1; first_wr_lo = -1; cs_hi_run = 0;
      rdy_viol = 0; early_rdy = 0; wr_prev = 1'b1; rst_prev = 1'b1;
      cap_rs.delete(); cap_dat.delete(); cap_cyc.delete(); cap_cshi.delete();
    end else begin
      if (!lcd_rst) rst_lo_cnt++;
      if (!rst_prev && lcd_rst) rst_rise_cyc = cyc;
      if (!lcd_wr && first_wr_lo < 0) first_wr_lo = cyc;
      if (lcd_cs) cs_hi_run++;
      if (s_if.s_ready && (!lcd_wr || !wr_prev)) rdy_viol++;
      if (s_if.s_ready && !init_done) early_rdy++;
      if (!wr_prev && lcd_wr) begin
        cap_rs.push_back(lcd_rs);
        cap_dat.push_back(lcd_data);
        cap_cyc.push_back(cyc);
        cap_cshi.push_back(cs_hi_run);
        cs_hi_run = 0;
      end
      wr_prev  = lcd_wr;
      rst_prev = lcd_rst;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW+1:0] ent(input logic [1:0] t, input logic [DW-1:0] p);
    return {t, p};
  endfunction

  function automatic logic [24:0] outs();
    return {rom_addr, lcd_data, lcd_cs, lcd_rs, lcd_wr, lcd_rst, init_done, init_err, s_if.s_ready};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    s_if.s_valid = 1'b0;
    repeat (3) @(negedge clk_use);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!init_done && n < 5000) begin
      @(negedge clk_use);
      n++;
    end
    check(tag, init_done, 1);
  endtask

  // Presents one beat and returns on the falling edge after it is accepted.
  task automatic send_beat(input logic rs, input logic [DW-1:0] d, input int gap, output logic ok);
    int n = 0;
    s_if.s_valid = 1'b0;
    repeat (gap) @(negedge clk_use);
    s_if.s_valid = 1'b1;
    s_if.s_rs    = rs;
    s_if.s_data  = d;
    while (!s_if.s_ready && n < 50) begin
      @(negedge clk_use);
      n++;
    end
    ok = (n < 50);
    @(negedge clk_use);
  endtask

  initial begin
    int   bad;
    int   tmo;
    logic ok;
    s_if.s_valid = 1'b0;
    s_if.s_rs    = 1'b0;
    s_if.s_data  = '0;

    // ---- T1/T2: reset values, reset pulse timing, CMD/DAT/END table ----
    rom[0] = ent(CMD, 16'h0011); rom[1] = ent(DAT, 16'h0055);
    rom[2] = ent(ENDT, 16'h0000); rom[3] = ent(CMD, 16'h0077);
    repeat (3) @(negedge clk_use);
    check("reset_values", outs(), EXP_RST);
    reset = 1'b0;
    s_if.s_valid = 1'b1;              // must be ignored until init_done
    s_if.s_rs = 1'b1; s_if.s_data = 16'hDEAD;
    wait_done("t2_done");
    s_if.s_valid = 1'b0;
    check("t1_rst_low_cycles", rst_lo_cnt, 4);
    // Fetch 4 cycles after lcd_rst rises, decode at +5, strobe low at +6.
    check("t1_rise_to_wr_low", first_wr_lo - rst_rise_cyc, 6);
    check("t2_nwrites", cap_rs.size(), 2);
    if (cap_rs.size() == 2) begin
      check("t2_w0", {cap_rs[0], cap_dat[0]}, {1'b0, 16'h0011});
      check("t2_w1", {cap_rs[1], cap_dat[1]}, {1'b1, 16'h0055});
    end
    check("t2_status", {init_done, init_err, lcd_cs, s_if.s_ready}, 4'b1011);
    check("t2_no_early_ready", early_rdy, 0);

    // ---- T5: 100 stream beats, first 10 back-to-back, then random gaps ----
    tmo = 0;
    for (int i = 0; i < 100; i++) begin
      send_beat((i % 5) != 0, 16'(i * 1031 + 7), (i < 10) ? 0 : int'($urandom_range(0, 3)), ok);
      if (!ok) tmo++;
    end
    s_if.s_valid = 1'b0;
    repeat (10) @(negedge clk_use);
    check("t5_accept_timeouts", tmo, 0);
    check("t5_nwrites", cap_rs.size(), 102);
    if (cap_rs.size() == 102) begin
      bad = 0;
      for (int i = 0; i < 100; i++)
        if (cap_rs[2+i] !== ((i % 5) != 0) || cap_dat[2+i] !== 16'(i * 1031 + 7)) bad++;
      check("t5_order_content", bad, 0);
      bad = 0;
      for (int i = 1; i < 10; i++)
        if (cap_cyc[2+i] - cap_cyc[1+i] != 4) bad++;
      check("t5_b2b_period", bad, 0);
      check("t5_cs_low_b2b", cap_cshi[11], 0);
    end
    check("t5_ready_during_write", rdy_viol, 0);
    check("t5_idle_cs_high", lcd_cs, 1);

    // ---- T3: DLY 3 with DELAY_UNIT=10 between two commands ----
    rom[0] = ent(CMD, 16'h0029); rom[1] = ent(DLY, 16'd3);
    rom[2] = ent(CMD, 16'h002C); rom[3] = ent(ENDT, 16'h0000);
    do_reset();
    wait_done("t3_done");
    check("t3_nwrites", cap_rs.size(), 2);
    if (cap_rs.size() == 2) begin
      // WR_HI, FETCH, DECODE, 30 x DELAY, FETCH, DECODE, 2 x WR_LO, WR_HI.
      check("t3_gap", cap_cyc[1] - cap_cyc[0], 37);
      check("t3_cs_high_in_gap", cap_cshi[1], 32);
      check("t3_w1", {cap_rs[1], cap_dat[1]}, {1'b0, 16'h002C});
    end

    // ---- T3b: DLY 0 costs only its fetch/decode, no countdown, cs untouched ----
    rom[1] = ent(DLY, 16'd0);
    do_reset();
    wait_done("t3b_done");
    check("t3b_nwrites", cap_rs.size(), 2);
    if (cap_rs.size() == 2) begin
      check("t3b_gap", cap_cyc[1] - cap_cyc[0], 7);
      check("t3b_cs_high_in_gap", cap_cshi[1], 0);
    end

    // ---- T4: table of 4 commands with no END ----
    rom[0] = ent(CMD, 16'h00A0); rom[1] = ent(CMD, 16'h00A1);
    rom[2] = ent(CMD, 16'h00A2); rom[3] = ent(CMD, 16'h00A3);
    do_reset();
    s_if.s_valid = 1'b1; s_if.s_rs = 1'b1; s_if.s_data = 16'hBEEF;
    wait_done("t4_done");
    s_if.s_valid = 1'b0;
    check("t4_nwrites", cap_rs.size(), 4);
    if (cap_rs.size() == 4) check("t4_last", {cap_rs[3], cap_dat[3]}, {1'b0, 16'h00A3});
    check("t4_err_done_addr", {init_err, init_done, rom_addr}, {1'b1, 1'b1, 2'd3});
    check("t4_no_early_ready", early_rdy, 0);
    repeat (8) @(negedge clk_use);
    check("t4_addr_no_wrap", rom_addr, 2'd3);

    // ---- T6a: reset in the middle of a long DELAY ----
    rom[0] = ent(CMD, 16'h002A); rom[1] = ent(DLY, 16'd200);
    rom[2] = ent(CMD, 16'h0036); rom[3] = ent(ENDT, 16'h0000);
    do_reset();
    tmo = 0;
    while (cap_rs.size() < 1 && tmo < 200) begin
      @(negedge clk_use);
      tmo++;
    end
    repeat (20) @(negedge clk_use);
    check("t6a_in_delay", {rom_addr, lcd_cs}, {2'd1, 1'b1});
    reset = 1'b1;
    @(negedge clk_use);
    check("t6a_reset_values", outs(), EXP_RST);
    repeat (2) @(negedge clk_use);
    reset = 1'b0;
    wait_done("t6a_replay_done");
    check("t6a_replay_rst_low", rst_lo_cnt, 4);
    check("t6a_replay_nwrites", cap_rs.size(), 2);

    // ---- T6b: reset during a RUN write ----
    send_beat(1'b1, 16'h1234, 0, ok);
    s_if.s_valid = 1'b0;
    check("t6b_in_write", {ok, lcd_wr, lcd_data}, {1'b1, 1'b0, 16'h1234});
    reset = 1'b1;
    @(negedge clk_use);
    check("t6b_reset_values", outs(), EXP_RST);
    repeat (2) @(negedge clk_use);
    reset = 1'b0;
    wait_done("t6b_replay_done");
    check("t6b_replay_rst_low", rst_lo_cnt, 4);
    check("t6b_replay_rise_to_wr_low", first_wr_lo - rst_rise_cyc, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
